// File: rtl/gpio_mulpop_pkg.sv
// Shared constants for the GPIO multiply + popcount coprocessor: register map,
// FSM encoding and status bit positions.
package gpio_mulpop_pkg;

    localparam logic [15:0] ADDR_A1   = 16'h037F;
    localparam logic [15:0] ADDR_A2   = 16'h0388;
    localparam logic [15:0] ADDR_W    = 16'h0390;
    localparam logic [15:0] ADDR_L    = 16'h0398;
    localparam logic [15:0] ADDR_CTRL = 16'h03A0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MULT  = 2'd1,
        ST_COUNT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int STAT_VALID = 0;
    localparam int STAT_READY = 1;
    localparam int STAT_BUSY  = 2;
    localparam int STAT_ERR   = 3;

    function automatic logic [31:0] pack_stat(input logic err, input logic busy,
                                              input logic ready, input logic valid);
        logic [31:0] s;
        s             = 32'd0;
        s[STAT_ERR]   = err;
        s[STAT_BUSY]  = busy;
        s[STAT_READY] = ready;
        s[STAT_VALID] = valid;
        return s;
    endfunction

endpackage

// File: rtl/gpio_mulpop_if.sv
// Host register bus of the GPIO emulator: address, level strobes and data.
interface gpio_mulpop_if;
    logic [15:0] saddress;
    logic        srd;
    logic        swr;
    logic [31:0] sdata_in;
    logic [31:0] sdata_out;

    modport master (output saddress, output srd, output swr, output sdata_in, input sdata_out);
    modport slave  (input saddress, input srd, input swr, input sdata_in, output sdata_out);
endinterface

// File: rtl/mulpop_shift_mult.sv
// Sequential shift-add multiplier: bit 0 is consumed on the start edge, so the
// full product sits in product with done high exactly OPW-1 clocks later.
module mulpop_shift_mult
    import gpio_mulpop_pkg::*;
#(
    parameter int OPW = 24
) (
    input  logic               clk,
    input  logic               n_reset,
    input  logic               start,
    input  logic [OPW-1:0]     mcand,
    input  logic [OPW-1:0]     mplier,
    output logic               done,
    output logic [2*OPW-1:0]   product
);

    localparam int PW = 2 * OPW;

    logic              run_r;
    logic              done_r;
    logic [5:0]        step_r;
    logic [PW-1:0]     mcand_r;
    logic [OPW-1:0]    mplier_r;
    logic [PW-1:0]     acc_r;
    logic [PW-1:0]     addend_s;

    // Partial product selected by the current multiplier bit
    always_comb begin
        addend_s = {PW{1'b0}};
        if (mplier_r[0]) begin
            addend_s = mcand_r;
        end else begin
            addend_s = {PW{1'b0}};
        end
    end

    // Shift-add datapath and step sequencing
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            run_r    <= 1'b0;
            done_r   <= 1'b0;
            step_r   <= 6'd0;
            mcand_r  <= {PW{1'b0}};
            mplier_r <= {OPW{1'b0}};
            acc_r    <= {PW{1'b0}};
        end else if (start) begin
            acc_r    <= mplier[0] ? {{OPW{1'b0}}, mcand} : {PW{1'b0}};
            mcand_r  <= {{(OPW-1){1'b0}}, mcand, 1'b0};
            mplier_r <= {1'b0, mplier[OPW-1:1]};
            step_r   <= 6'd1;
            run_r    <= 1'b1;
            done_r   <= 1'b0;
        end else if (run_r) begin
            acc_r    <= acc_r + addend_s;
            mcand_r  <= {mcand_r[PW-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[OPW-1:1]};
            step_r   <= step_r + 6'd1;
            if (step_r == 6'(OPW - 1)) begin
                run_r  <= 1'b0;
                done_r <= 1'b1;
            end
        end else begin
            done_r <= 1'b0;
        end
    end

    assign done    = done_r;
    assign product = acc_r;

endmodule

// File: rtl/gpio_mulpop_unit.sv
// Bus-mapped multiply + popcount coprocessor with job counter on gpio_out.
// Build option GPIO_MULPOP_SAT_EN: saturate W to all-ones on product overflow.
module gpio_mulpop_unit
    import gpio_mulpop_pkg::*;
#(
    parameter int OPW  = 24,
    parameter int RESW = 32,
    parameter int CNTW = 16
) (
    input  logic         clk,
    input  logic         n_reset,
    gpio_mulpop_if.slave bus,
    input  logic [31:0]  gpio_in,
    input  logic         gpio_latch,
    output logic [31:0]  gpio_in_s_insp,
    output logic [31:0]  gpio_out
);

    localparam int LW = $clog2(RESW + 1);

    state_e              state_r, next_state_s;
    logic                srd_q_r, swr_q_r, latch_q_r;
    logic                rd_edge_s, wr_edge_s, latch_edge_s;
    logic                wr_a1_s, wr_a2_s, start_req_s, accept_s, reject_s;
    logic [OPW-1:0]      a1_r, a2_r;
    logic                mult_done_s, ovf_s;
    logic [2*OPW-1:0]    prod_s;
    logic [RESW-1:0]     w_next_s, w_r, pc_sh_r;
    logic [LW-1:0]       l_r;
    logic [5:0]          cnt_idx_r;
    logic [CNTW-1:0]     jobs_r;
    logic                ready_r, valid_r, busy_r, err_r;
    logic [31:0]         rd_data_s, sdata_out_r, insp_r;
    logic                unused_s;

    // Strobe history for rising-edge detection
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            srd_q_r   <= 1'b0;
            swr_q_r   <= 1'b0;
            latch_q_r <= 1'b0;
        end else begin
            srd_q_r   <= bus.srd;
            swr_q_r   <= bus.swr;
            latch_q_r <= gpio_latch;
        end
    end

    assign rd_edge_s    = bus.srd & ~srd_q_r;
    assign wr_edge_s    = bus.swr & ~swr_q_r;
    assign latch_edge_s = gpio_latch & ~latch_q_r;
    assign unused_s     = ^bus.sdata_in;

    // Write decode; writes that hit a busy block are refused and flagged
    always_comb begin
        wr_a1_s     = 1'b0;
        wr_a2_s     = 1'b0;
        start_req_s = 1'b0;
        case (bus.saddress)
            ADDR_A1:   wr_a1_s     = wr_edge_s;
            ADDR_A2:   wr_a2_s     = wr_edge_s;
            ADDR_CTRL: start_req_s = wr_edge_s;
            default:   wr_a1_s     = 1'b0;
        endcase
    end

    assign accept_s = start_req_s & (state_r == ST_IDLE);
    assign reject_s = (wr_a1_s | wr_a2_s | start_req_s) & busy_r;

    mulpop_shift_mult #(.OPW(OPW)) u_mult (
        .clk     (clk),
        .n_reset (n_reset),
        .start   (accept_s),
        .mcand   (a1_r),
        .mplier  (a2_r),
        .done    (mult_done_s),
        .product (prod_s)
    );

    if (RESW < 2 * OPW) begin : g_ovf
        assign ovf_s = |prod_s[2*OPW-1:RESW];
    end else begin : g_no_ovf
        assign ovf_s = 1'b0;
    end

`ifdef GPIO_MULPOP_SAT_EN
    assign w_next_s = ovf_s ? {RESW{1'b1}} : prod_s[RESW-1:0];
`else
    assign w_next_s = prod_s[RESW-1:0];
`endif

    // FSM state register
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE:  if (accept_s) next_state_s = ST_MULT; else next_state_s = ST_IDLE;
            ST_MULT:  if (mult_done_s) next_state_s = ST_COUNT; else next_state_s = ST_MULT;
            ST_COUNT: if (cnt_idx_r == 6'(RESW - 1)) next_state_s = ST_DONE; else next_state_s = ST_COUNT;
            ST_DONE:  next_state_s = ST_IDLE;
            default:  next_state_s = ST_IDLE;
        endcase
    end

    // Operand registers, frozen while a job runs
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            a1_r <= {OPW{1'b0}};
            a2_r <= {OPW{1'b0}};
        end else begin
            if (wr_a1_s && !busy_r) a1_r <= bus.sdata_in[OPW-1:0];
            if (wr_a2_s && !busy_r) a2_r <= bus.sdata_in[OPW-1:0];
        end
    end

    // Status flags
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            ready_r <= 1'b1;
            valid_r <= 1'b1;
            busy_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                ready_r <= 1'b0;
                valid_r <= 1'b1;
                busy_r  <= 1'b1;
                err_r   <= 1'b0;
            end else if (reject_s) begin
                err_r <= 1'b1;
            end
            if (state_r == ST_MULT && mult_done_s) valid_r <= ~ovf_s;
            if (state_r == ST_DONE) begin
                ready_r <= 1'b1;
                busy_r  <= 1'b0;
            end
        end
    end

    // Result capture and bit-serial popcount of W (LSB first)
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            w_r       <= {RESW{1'b0}};
            pc_sh_r   <= {RESW{1'b0}};
            l_r       <= {LW{1'b0}};
            cnt_idx_r <= 6'd0;
        end else if (state_r == ST_MULT && mult_done_s) begin
            w_r       <= w_next_s;
            pc_sh_r   <= w_next_s;
            l_r       <= {LW{1'b0}};
            cnt_idx_r <= 6'd0;
        end else if (state_r == ST_COUNT) begin
            l_r       <= l_r + LW'(pc_sh_r[0]);
            pc_sh_r   <= {1'b0, pc_sh_r[RESW-1:1]};
            cnt_idx_r <= cnt_idx_r + 6'd1;
        end
    end

    // Completed-job counter, wraps naturally
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            jobs_r <= {CNTW{1'b0}};
        end else if (state_r == ST_DONE) begin
            jobs_r <= jobs_r + CNTW'(1'b1);
        end
    end

    // Read mux on pre-edge register contents
    always_comb begin
        rd_data_s = 32'd0;
        case (bus.saddress)
            ADDR_A1:   rd_data_s = 32'(a1_r);
            ADDR_A2:   rd_data_s = 32'(a2_r);
            ADDR_W:    rd_data_s = 32'(w_r);
            ADDR_L:    rd_data_s = 32'(l_r);
            ADDR_CTRL: rd_data_s = pack_stat(err_r, busy_r, ready_r, valid_r);
            default:   rd_data_s = 32'd0;
        endcase
    end

    // Read data and GPIO input capture
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sdata_out_r <= 32'd0;
            insp_r      <= 32'd0;
        end else begin
            if (rd_edge_s)    sdata_out_r <= rd_data_s;
            if (latch_edge_s) insp_r      <= gpio_in;
        end
    end

    assign bus.sdata_out    = sdata_out_r;
    assign gpio_in_s_insp   = insp_r;
    assign gpio_out         = 32'(jobs_r);

endmodule

// File: tb/tb_gpio_mulpop_unit.sv
// Scoreboard bench: drivers push expected read responses from a job-level
// model; a monitor pops and compares on every read response.
module tb_gpio_mulpop_unit;
    import gpio_mulpop_pkg::*;

    localparam int OPW  = 24;
    localparam int RESW = 32;
    localparam int CNTW = 4;
    localparam int LAT  = OPW + RESW + 1;
    localparam logic [31:0] OPMASK = 32'((64'd1 << OPW) - 64'd1);

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic [31:0] gpio_in = 32'd0;
    logic        gpio_latch = 1'b0;
    logic [31:0] gpio_in_s_insp, gpio_out;

    gpio_mulpop_if bus();

    gpio_mulpop_unit #(.OPW(OPW), .RESW(RESW), .CNTW(CNTW)) dut (
        .clk            (clk),
        .n_reset        (n_reset),
        .bus            (bus),
        .gpio_in        (gpio_in),
        .gpio_latch     (gpio_latch),
        .gpio_in_s_insp (gpio_in_s_insp),
        .gpio_out       (gpio_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
        logic [31:0] gout;
        logic [31:0] insp;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   edge_no = 0;

    // job-level reference model
    logic [31:0] m_a1, m_a2, m_w_old, m_l_old, m_insp, job_w, job_l;
    bit          m_err, m_active, job_valid;
    int          m_start, m_done_jobs;

    initial forever begin
        @(posedge clk);
        edge_no++;
    end

    task automatic check(input string nm, input logic [15:0] addr,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s addr=%h: got %h expected %h", nm, addr, act, exp);
    endtask

    function automatic bit busy_at(int e);
        return m_active && (m_start < e) && (e <= m_start + LAT);
    endfunction

    function automatic bit prod_seen(int e);
        return m_active && (e - 1 >= m_start + OPW);
    endfunction

    function automatic logic [31:0] exp_read(logic [15:0] addr, int e);
        bit b;
        bit v;
        b = busy_at(e);
        v = prod_seen(e) ? job_valid : 1'b1;
        case (addr)
            ADDR_A1:   return m_a1;
            ADDR_A2:   return m_a2;
            ADDR_W:    return prod_seen(e) ? job_w : m_w_old;
            ADDR_L:    return prod_seen(e) ? job_l : m_l_old;
            ADDR_CTRL: return {28'd0, m_err, b, !b, v};
            default:   return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] exp_cnt(int e);
        int n;
        n = m_done_jobs + ((m_active && e >= m_start + LAT) ? 1 : 0);
        return 32'(n % (1 << CNTW));
    endfunction

    task automatic model_write(input logic [15:0] addr, input logic [31:0] data, input int e);
        logic [63:0] p;
        bit b;
        b = busy_at(e);
        if (addr == ADDR_A1) begin
            if (b) m_err = 1'b1; else m_a1 = data & OPMASK;
        end else if (addr == ADDR_A2) begin
            if (b) m_err = 1'b1; else m_a2 = data & OPMASK;
        end else if (addr == ADDR_CTRL) begin
            if (b) m_err = 1'b1;
            else begin
                if (m_active) begin
                    m_done_jobs++;
                    m_w_old = job_w;
                    m_l_old = job_l;
                end
                p = {32'd0, m_a1} * {32'd0, m_a2};
                job_valid = ((p >> RESW) == 64'd0);
`ifdef GPIO_MULPOP_SAT_EN
                job_w = job_valid ? p[31:0] : 32'hFFFF_FFFF;
`else
                job_w = p[31:0];
`endif
                job_l = 32'($countones(job_w));
                m_active = 1'b1;
                m_start = e;
                m_err = 1'b0;
            end
        end
    endtask

    // one bus access: strobes high for the edge after this negedge, then low
    task automatic bus_op(input bit rd, input bit wr, input logic [15:0] addr, input logic [31:0] data);
        int e;
        exp_t x;
        e = edge_no + 1;
        if (rd) begin
            x.addr = addr;
            x.data = exp_read(addr, e);
            x.gout = exp_cnt(e);
            x.insp = m_insp;
            exp_q.push_back(x);
        end
        if (wr) model_write(addr, data, e);
        bus.saddress = addr;
        bus.sdata_in = data;
        bus.srd = rd;
        bus.swr = wr;
        @(negedge clk);
        bus.srd = 1'b0;
        bus.swr = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_to(input int t);
        while (edge_no + 1 < t) @(negedge clk);
    endtask

    task automatic do_reset();
        bus.srd = 1'b0;
        bus.swr = 1'b0;
        gpio_latch = 1'b0;
        n_reset = 1'b0;
        m_a1 = 32'd0; m_a2 = 32'd0; m_w_old = 32'd0; m_l_old = 32'd0; m_insp = 32'd0;
        job_w = 32'd0; job_l = 32'd0; job_valid = 1'b1;
        m_err = 1'b0; m_active = 1'b0; m_start = 0; m_done_jobs = 0;
        repeat (3) @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic latch_gpio(input logic [31:0] v);
        gpio_in = v;
        gpio_latch = 1'b1;
        m_insp = v;
        @(negedge clk);
        gpio_latch = 1'b0;
        @(negedge clk);
    endtask

    task automatic start_job(input logic [31:0] a, input logic [31:0] b, output int s);
        bus_op(1'b0, 1'b1, ADDR_A1, a);
        bus_op(1'b0, 1'b1, ADDR_A2, b);
        s = edge_no + 1;
        bus_op(1'b0, 1'b1, ADDR_CTRL, 32'd1);
    endtask

    task automatic run_job(input logic [31:0] a, input logic [31:0] b);
        int s;
        start_job(a, b, s);
        wait_to(s + LAT + 1);
        bus_op(1'b1, 1'b0, ADDR_CTRL, 32'd0);
        bus_op(1'b1, 1'b0, ADDR_W, 32'd0);
        bus_op(1'b1, 1'b0, ADDR_L, 32'd0);
    endtask

    function automatic logic [31:0] pick_op();
        case ($urandom_range(0, 3))
            0:       return 32'd0;
            1:       return 32'($urandom_range(0, 15));
            2:       return OPMASK;
            default: return $urandom & OPMASK;
        endcase
    endfunction

    // monitor: compare every read response against the scoreboard head
    initial begin
        bit   q;
        exp_t e;
        q = 1'b0;
        forever begin
            @(posedge clk);
            if (bus.srd && !q) begin
                q = 1'b1;
                @(negedge clk);
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_read: got %h expected no response", bus.sdata_out);
                end else begin
                    e = exp_q.pop_front();
                    check("rd_data", e.addr, bus.sdata_out, e.data);
                    check("gpio_out", e.addr, gpio_out, e.gout);
                    check("gpio_in_s_insp", e.addr, gpio_in_s_insp, e.insp);
                end
            end else begin
                q = bus.srd;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int s;
        bus.saddress = 16'd0;
        bus.sdata_in = 32'd0;
        bus.srd = 1'b0;
        bus.swr = 1'b0;
        do_reset();

        // reset state
        bus_op(1'b1, 1'b0, ADDR_CTRL, 32'd0);
        bus_op(1'b1, 1'b0, ADDR_A1, 32'd0);
        bus_op(1'b1, 1'b0, ADDR_W, 32'd0);
        bus_op(1'b1, 1'b0, ADDR_L, 32'd0);

        // 3*5, STAT just after start, in the DONE cycle, and once ready
        start_job(32'd3, 32'd5, s);
        bus_op(1'b1, 1'b0, ADDR_CTRL, 32'd0);
        wait_to(s + LAT);
        bus_op(1'b1, 1'b0, ADDR_CTRL, 32'd0);
        bus_op(1'b1, 1'b0, ADDR_CTRL, 32'd0);
        bus_op(1'b1, 1'b0, ADDR_W, 32'd0);
        bus_op(1'b1, 1'b0, ADDR_L, 32'd0);

        // overflow: valid drops right after MULT, ready exactly at LAT
        start_job(OPMASK, OPMASK, s);
        wait_to(s + OPW + 1);
        bus_op(1'b1, 1'b0, ADDR_CTRL, 32'd0);
        wait_to(s + LAT + 1);
        bus_op(1'b1, 1'b0, ADDR_CTRL, 32'd0);
        bus_op(1'b1, 1'b0, ADDR_W, 32'd0);
        bus_op(1'b1, 1'b0, ADDR_L, 32'd0);

        // writes while busy are ignored and set err; next start clears it
        start_job($urandom & OPMASK, $urandom & OPMASK, s);
        wait_to(s + 5);
        bus_op(1'b0, 1'b1, ADDR_A1, 32'd7);
        bus_op(1'b0, 1'b1, ADDR_CTRL, 32'd1);
        bus_op(1'b0, 1'b1, 16'h0400, 32'd9);
        bus_op(1'b1, 1'b0, ADDR_CTRL, 32'd0);
        wait_to(s + LAT + 1);
        bus_op(1'b1, 1'b0, ADDR_W, 32'd0);
        bus_op(1'b1, 1'b0, ADDR_A1, 32'd0);
        bus_op(1'b1, 1'b0, ADDR_CTRL, 32'd0);
        s = edge_no + 1;
        bus_op(1'b0, 1'b1, ADDR_CTRL, 32'd1);
        bus_op(1'b1, 1'b0, ADDR_CTRL, 32'd0);
        wait_to(s + LAT + 1);
        bus_op(1'b1, 1'b0, ADDR_W, 32'd0);

        // reset in the middle of MULT aborts the job
        start_job($urandom & OPMASK, $urandom & OPMASK, s);
        wait_to(s + 10);
        do_reset();
        bus_op(1'b1, 1'b0, ADDR_CTRL, 32'd0);
        bus_op(1'b1, 1'b0, ADDR_W, 32'd0);
        bus_op(1'b1, 1'b0, ADDR_L, 32'd0);
        run_job($urandom & OPMASK, $urandom & OPMASK);

        // random jobs, enough to wrap the completion counter
        for (int i = 0; i < 20; i++) begin
            if (i == 0) run_job(32'd0, $urandom & OPMASK);
            else run_job(pick_op(), pick_op());
            if (i % 5 == 2) begin
                bus_op(1'b1, 1'b1, ADDR_A1, $urandom);
                bus_op(1'b1, 1'b0, ADDR_A1, 32'd0);
                bus_op(1'b0, 1'b1, 16'h0400, $urandom);
                bus_op(1'b1, 1'b0, 16'h0400, 32'd0);
            end
        end

        // gpio capture while a job is running
        start_job($urandom & OPMASK, $urandom & OPMASK, s);
        wait_to(s + 3);
        latch_gpio(32'hA5A5_A5A5);
        bus_op(1'b1, 1'b0, ADDR_CTRL, 32'd0);
        wait_to(s + LAT + 1);
        latch_gpio($urandom);
        bus_op(1'b1, 1'b0, ADDR_L, 32'd0);
        bus_op(1'b1, 1'b0, ADDR_CTRL, 32'd0);

        repeat (4) @(negedge clk);
        check("scoreboard_drain", 16'h0000, 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
